// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and sizing helper for the circular FIFO.
//   DEF_DATA_W : default data word width
//   DEF_DEPTH  : default number of storage entries (power of two)
//   ptr_w()    : pointer/count width, clog2(depth) address bits plus one
//                wrap bit (also wide enough to hold a count of 0..depth)
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W storage with one synchronous write port and one synchronous
// read port. Contents are never reset.
// Ports:
//   clk      : clock, both ports update on the rising edge
//   wr_en    : write strobe, stores wr_data at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, loads mem[rd_addr] into rd_data
//   rd_addr  : read address
//   rd_data  : registered read data, holds while rd_en is low
// -----------------------------------------------------------------------------
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // The controller never accepts a read and a write to the same entry in
   // one cycle (that needs an empty or a full FIFO), so no bypass is needed.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/param_circular_fifo.sv
// -----------------------------------------------------------------------------
// param_circular_fifo
// Single-clock circular FIFO with occupancy count, status flags and sticky
// overflow/underflow error flags.
// Handshake: a write is accepted on a rising edge when write_en=1 and full=0;
// a read is accepted when read_en=1 and empty=0 and its word appears on
// data_out after that edge. Rejected requests have no effect on the data.
// Ports:
//   clk          : clock
//   reset        : asynchronous active-low reset
//   write_en     : write request          data_in : write data
//   read_en      : read request           clr_err : clears sticky errors
//   data_out     : registered read data, holds between accepted reads
//   full, empty, almost_full, almost_empty : status derived from count
//   count        : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
// -----------------------------------------------------------------------------
module param_circular_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     write_en,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     read_en,
   input  logic                     clr_err,
   output logic [DATA_W-1:0]        data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [ptr_w(DEPTH)-1:0]  count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int CW = ptr_w(DEPTH);
   localparam int AW = CW - 1;
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0]     wr_ptr, rd_ptr, count_q;
   logic              do_wr, do_rd;
   logic              overflow_set, underflow_set;
   logic              rd_seen;
   logic [DATA_W-1:0] mem_rd_data;

   // Status flags come straight from the registered count.
   assign count        = count_q;
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));

   assign do_wr = write_en & ~full;
   assign do_rd = read_en & ~empty;

   // A write against a full FIFO is an overflow unless a read is requested
   // in the same cycle; then the read drains an entry and the dropped write
   // is treated as a retry-able collision rather than an error.
   assign overflow_set  = write_en & full & ~read_en;
   assign underflow_set = read_en & empty;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (do_wr),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (data_in),
      .rd_en   (do_rd),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (mem_rd_data)
   );

   // The storage read register has no reset, so data_out reads as zero
   // until the first read accepted after reset refreshes it.
   assign data_out = rd_seen ? mem_rd_data : '0;

   // Pointers are CW bits wide: incrementing past DEPTH-1 rolls the address
   // to 0 and toggles the top (wrap) bit, since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         rd_seen   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + ONE;
         if (do_rd) begin
            rd_ptr  <= rd_ptr + ONE;
            rd_seen <= 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + ONE;
            2'b01:   count_q <= count_q - ONE;
            default: count_q <= count_q;
         endcase
         // A new error event in the clearing cycle keeps the flag set.
         overflow  <= overflow_set  | (overflow  & ~clr_err);
         underflow <= underflow_set | (underflow & ~clr_err);
      end
   end

   // The wrap-bit pointer distance must always equal the occupancy.
   a_ptr_count : assert property (@(posedge clk) disable iff (!reset)
      (CW'(wr_ptr - rd_ptr) == count_q));

endmodule

// File: tb/tb_param_circular_fifo.sv
module tb_param_circular_fifo;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 8;
   localparam int AF     = 6;
   localparam int AE     = 2;

   logic              clk;
   logic              reset;
   logic              write_en;
   logic [DATA_W-1:0] data_in;
   logic              read_en;
   logic              clr_err;
   logic [DATA_W-1:0] data_out;
   logic              full, empty, almost_full, almost_empty;
   logic [3:0]        count;
   logic              overflow, underflow;

   int checks = 0;
   int errors = 0;

   // Reference model: queue contents, last read word, sticky flags.
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] m_dout;
   logic              m_ovf, m_udf;

   param_circular_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .write_en     (write_en),
      .data_in      (data_in),
      .read_en      (read_en),
      .clr_err      (clr_err),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = exp_q.size();
      check({tag, "_count"},  32'(count),        32'(n));
      check({tag, "_full"},   32'(full),         32'(n == DEPTH));
      check({tag, "_empty"},  32'(empty),        32'(n == 0));
      check({tag, "_afull"},  32'(almost_full),  32'(n >= AF));
      check({tag, "_aempty"}, 32'(almost_empty), 32'(n <= AE));
      check({tag, "_dout"},   32'(data_out),     32'(m_dout));
      check({tag, "_ovf"},    32'(overflow),     32'(m_ovf));
      check({tag, "_udf"},    32'(underflow),    32'(m_udf));
   endtask

   // Applies the FIFO rules to the model for one rising edge.
   task automatic model_step(input logic we, input logic [DATA_W-1:0] din,
                             input logic re, input logic clr);
      logic was_full, was_empty, ovf_ev, udf_ev;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      ovf_ev    = we && was_full && !re;
      udf_ev    = re && was_empty;
      if (re && !was_empty) m_dout = exp_q.pop_front();
      if (we && !was_full)  exp_q.push_back(din);
      m_ovf = ovf_ev || (m_ovf && !clr);
      m_udf = udf_ev || (m_udf && !clr);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge; drives inputs, lets one rising edge
   // pass, then checks outputs at the next falling edge.
   task automatic cycle(input string tag, input logic we, input logic [DATA_W-1:0] din,
                        input logic re, input logic clr);
      write_en = we;
      data_in  = din;
      read_en  = re;
      clr_err  = clr;
      @(posedge clk);
      model_step(we, din, re, clr);
      @(negedge clk);
      check_all(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DATA_W-1:0] pattern [8];
      logic [DATA_W-1:0] held;
      pattern = '{4'd8, 4'd12, 4'd4, 4'd7, 4'd13, 4'd9, 4'd11, 4'd5};

      reset    = 1'b1;
      write_en = 1'b0;
      data_in  = '0;
      read_en  = 1'b0;
      clr_err  = 1'b0;
      model_reset();

      // Reset state, applied before any clock edge.
      #1 reset = 1'b0;
      #1 check_all("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_all("reset_rel");

      // Fill to full, then one write too many.
      for (int i = 0; i < 8; i++) cycle("fill", 1'b1, pattern[i], 1'b0, 1'b0);
      check("fill_full", 32'(full), 32'd1);
      cycle("ovf_wr", 1'b1, 4'd3, 1'b0, 1'b0);

      // Drain in order, then one read too many.
      for (int i = 0; i < 8; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      cycle("udf_rd", 1'b0, '0, 1'b1, 1'b0);
      check("udf_hold_dout", 32'(data_out), 32'd5);
      cycle("clr_both", 1'b0, '0, 1'b0, 1'b1);

      // Steady count=3 with simultaneous requests; pointers wrap.
      for (int i = 0; i < 3; i++) cycle("pre3", 1'b1, DATA_W'($urandom_range(0, 15)), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle("both3", 1'b1, DATA_W'($urandom_range(0, 15)), 1'b1, 1'b0);
      check("both3_count", 32'(count), 32'd3);

      // Both requests while empty.
      while (exp_q.size() > 0) cycle("to_empty", 1'b0, '0, 1'b1, 1'b0);
      held = data_out;
      cycle("both_empty", 1'b1, 4'd6, 1'b1, 1'b0);
      check("both_empty_dout", 32'(data_out), 32'(held));

      // Both requests while full.
      while (exp_q.size() < DEPTH) cycle("to_full", 1'b1, DATA_W'($urandom_range(0, 15)), 1'b0, 1'b0);
      cycle("both_full", 1'b1, 4'd1, 1'b1, 1'b0);
      check("both_full_count", 32'(count), 32'd7);
      check("both_full_ovf", 32'(overflow), 32'd0);

      // Sticky overflow clear, and set-wins-over-clear.
      cycle("refill", 1'b1, 4'd2, 1'b0, 1'b0);
      cycle("set_ovf", 1'b1, 4'd2, 1'b0, 1'b0);
      cycle("clr_ovf", 1'b0, '0, 1'b0, 1'b1);
      check("clr_ovf_flag", 32'(overflow), 32'd0);
      cycle("clr_vs_set", 1'b1, 4'd2, 1'b0, 1'b1);
      check("clr_vs_set_flag", 32'(overflow), 32'd1);
      cycle("clr_final", 1'b0, '0, 1'b0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++)
         cycle("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

      // Reset mid-operation between clock edges at count=5.
      while (exp_q.size() > 0) cycle("pre_rst", 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle("to5", 1'b1, DATA_W'($urandom_range(0, 15)), 1'b0, 1'b0);
      cycle("rd_before_rst", 1'b1, 4'd9, 1'b1, 1'b0);
      write_en = 1'b0;
      read_en  = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      #1 check_all("rst_mid");
      check("rst_mid_dout", 32'(data_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cycle("post_rst_wr", 1'b1, 4'hA, 1'b0, 1'b0);
      cycle("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);
      check("post_rst_data", 32'(data_out), 32'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
